// File: rtl/tff_311_pkg.sv
// Shared defaults for the tff_311 toggle flip-flop bank.
package tff_311_pkg;

    localparam int   DEF_WIDTH     = 1;
    localparam logic DEF_RESET_BIT = 1'b0;

endpackage

// File: rtl/tff_311_bit.sv
// One toggle cell with asynchronous active-low reset.
module tff_bit #(
    parameter logic RESET_BIT = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic t,
    output logic q
);

    // XOR form keeps an unknown t visible as an unknown q in simulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= RESET_BIT;
        else
            q <= q ^ t;
    end

endmodule

// File: rtl/tff_311.sv
// WIDTH independent toggle flip-flops with a shared clock and async reset.
module tff_311
    import tff_311_pkg::*;
#(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{DEF_RESET_BIT}}
) (
    input  logic             clk_311,
    input  logic             reset,
    input  logic [WIDTH-1:0] t_311,
    output logic [WIDTH-1:0] q_311,
    output logic [WIDTH-1:0] qb_311
);

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            tff_bit #(
                .RESET_BIT (RESET_VAL[i])
            ) u_bit (
                .clk   (clk_311),
                .rst_n (reset),
                .t     (t_311[i]),
                .q     (q_311[i])
            );
        end
    endgenerate

    assign qb_311 = ~q_311;

endmodule

// File: tb/tb_tff_311.sv
// Directed checks on a default 1-bit bank, then random toggles on an 8-bit bank.
module tb_tff_311;

    localparam int         WW = 8;
    localparam logic [7:0] RV = 8'hA5;

    logic          clk;
    logic          reset;
    logic          t_n;
    logic          q_n, qb_n;
    logic [WW-1:0] t_w, q_w, qb_w;

    int checks = 0;
    int errors = 0;
    int cnt [WW];

    tff_311 dut (
        .clk_311 (clk),
        .reset   (reset),
        .t_311   (t_n),
        .q_311   (q_n),
        .qb_311  (qb_n)
    );

    tff_311 #(.WIDTH(WW), .RESET_VAL(RV)) dut_w (
        .clk_311 (clk),
        .reset   (reset),
        .t_311   (t_w),
        .q_311   (q_w),
        .qb_311  (qb_w)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected wide state: reset value flipped once per edge the bit saw t=1.
    function automatic logic [7:0] model_q();
        logic [7:0] r;
        for (int b = 0; b < WW; b++)
            r[b] = RV[b] ^ cnt[b][0];
        return r;
    endfunction

    initial begin
        logic [WW-1:0] fin;
        reset = 1'b1;
        t_n   = 1'b0;
        t_w   = '0;
        #1 reset = 1'b0;
        #8;
        chk("por_q",   {7'd0, q_n},  8'h00);
        chk("por_qb",  {7'd0, qb_n}, 8'h01);
        chk("por_qw",  q_w,  RV);
        chk("por_qbw", qb_w, ~RV);

        // Edges during reset are ignored even with t high.
        t_n = 1'b1;
        t_w = '1;
        tick();
        tick();
        chk("rst_ign_q",  {7'd0, q_n}, 8'h00);
        chk("rst_ign_qw", q_w, RV);

        #2;
        reset = 1'b1;
        t_n   = 1'b0;
        t_w   = '0;
        tick();
        chk("hold1_q",  {7'd0, q_n},  8'h00);
        chk("hold1_qb", {7'd0, qb_n}, 8'h01);
        tick();
        chk("hold2_q",  {7'd0, q_n},  8'h00);
        chk("hold2_qb", {7'd0, qb_n}, 8'h01);

        t_n = 1'b1;
        tick();
        t_n = 1'b0;
        chk("tog_q",  {7'd0, q_n},  8'h01);
        chk("tog_qb", {7'd0, qb_n}, 8'h00);
        tick();
        chk("tog_hold_q", {7'd0, q_n}, 8'h01);

        // Async reset between edges clears instantly.
        @(negedge clk);
        #1 reset = 1'b0;
        #1;
        chk("async_q",  {7'd0, q_n},  8'h00);
        chk("async_qb", {7'd0, qb_n}, 8'h01);
        t_n = 1'b1;
        tick();
        tick();
        chk("async_ign_q", {7'd0, q_n}, 8'h00);
        @(negedge clk);
        reset = 1'b1;

        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("div2_%0d", k), {7'd0, q_n}, (k % 2 == 0) ? 8'h01 : 8'h00);
        end
        t_n = 1'b0;

        // Pulse between edges must be invisible.
        @(negedge clk);
        #1 t_n = 1'b1;
        #2 t_n = 1'b0;
        tick();
        chk("pulse_q", {7'd0, q_n}, 8'h00);

        // Reset coincident with a toggling edge wins.
        t_n = 1'b1;
        @(posedge clk);
        reset = 1'b0;
        #1;
        chk("rst_coinc_q", {7'd0, q_n}, 8'h00);
        t_n = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int b = 0; b < WW; b++) cnt[b] = 0;

        // Random phase on the wide bank with mid-cycle glitches and resets.
        tick();
        chk("rand_start", q_w, RV);
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(15) == 0) begin
                t_w = WW'($urandom);
                #3 reset = 1'b0;
                #1;
                chk("rand_async", q_w, RV);
                chk("rand_async_qb", qb_w, ~RV);
                for (int b = 0; b < WW; b++) cnt[b] = 0;
                #1 reset = 1'b1;
                fin = t_w;
            end else begin
                t_w = WW'($urandom);
                #4;
                fin = WW'($urandom);
                t_w = fin;
            end
            tick();
            for (int b = 0; b < WW; b++)
                if (fin[b]) cnt[b]++;
            chk($sformatf("rand_q_%0d", i), q_w, model_q());
            chk($sformatf("rand_qb_%0d", i), qb_w, ~model_q());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
